// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the default operand width.
package seq_divider_pkg;

   localparam int DEFAULT_BITS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider.
// Handshake: start is honoured only while busy=0 and done=0; done is a
// one-cycle pulse, and quotient/remainder/div_by_zero stay valid until the
// next accepted start.
interface seq_divider_if #(
   parameter int N = 32
) ();

   logic         start;
   logic         is_signed;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_divider_subtractor_nbits.sv
// Combinational trial subtractor for the restoring divider: a - b with the
// borrow out (set when b > a).
module subtractor_nbits #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per clock, N+1 cycle latency.
// Optional macro SIGNED_DIV_EN enables signed operation through is_signed.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int NUMBER_OF_BITS = DEFAULT_BITS
) (
   input  logic      clk,
   input  logic      rst_n,
   seq_divider_if.slave bus,
   output state_t    fsm_state
);

   localparam int N  = NUMBER_OF_BITS;
   localparam int CW = $clog2(N + 1);

`ifdef SIGNED_DIV_EN
   localparam logic SIGN_EN = 1'b1;
`else
   localparam logic SIGN_EN = 1'b0;
`endif

   state_t        state;
   logic [CW-1:0] count;
   logic [N:0]    prem;
   logic [N-1:0]  dvd;
   logic [N-1:0]  dvs;
   logic          neg_q;
   logic          neg_r;
   logic          busy_q;
   logic          done_q;
   logic [N-1:0]  quot_q;
   logic [N-1:0]  rem_q;
   logic          dbz_q;

   logic          signed_req;
   logic          dvd_neg;
   logic          dvs_neg;
   logic [N-1:0]  dvd_mag;
   logic [N-1:0]  dvs_mag;
   logic [N:0]    shifted;
   logic [N:0]    diff;
   logic          borrow;
   logic [N:0]    r_next;
   logic [N-1:0]  q_next;
   logic [N-1:0]  q_fix;
   logic [N-1:0]  r_fix;

   // Signed requests iterate on magnitudes; signs are restored on the last step.
   assign signed_req = SIGN_EN & bus.is_signed;
   assign dvd_neg    = signed_req & bus.dividend[N-1];
   assign dvs_neg    = signed_req & bus.divisor[N-1];
   assign dvd_mag    = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
   assign dvs_mag    = dvs_neg ? (~bus.divisor + 1'b1)  : bus.divisor;

   assign shifted = (prem << 1) | {{N{1'b0}}, dvd[N-1]};

   subtractor_nbits #(.W(N + 1)) u_sub (
      .a      (shifted),
      .b      ({1'b0, dvs}),
      .diff   (diff),
      .borrow (borrow)
   );

   assign r_next = borrow ? shifted : diff;
   assign q_next = {dvd[N-2:0], ~borrow};
   assign q_fix  = neg_q ? (~q_next + 1'b1) : q_next;
   assign r_fix  = neg_r ? (~r_next[N-1:0] + 1'b1) : r_next[N-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         prem   <= '0;
         dvd    <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.divisor == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     quot_q <= '1;
                     rem_q  <= bus.dividend;
                     dbz_q  <= 1'b1;
                  end else begin
                     state  <= BUSY;
                     busy_q <= 1'b1;
                     dvd    <= dvd_mag;
                     dvs    <= dvs_mag;
                     prem   <= '0;
                     count  <= CW'(N);
                     neg_q  <= dvd_neg ^ dvs_neg;
                     neg_r  <= dvd_neg;
                  end
               end
            end
            BUSY: begin
               prem  <= r_next;
               dvd   <= q_next;
               count <= count - 1'b1;
               // Last iteration: results land together with the done pulse.
               if (count == CW'(1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  quot_q <= q_fix;
                  rem_q  <= r_fix;
                  dbz_q  <= 1'b0;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
   assign fsm_state       = state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=32): latency, results, divide-by-zero,
// ignored restarts, reset abort and the is_signed behaviour of the build.
module tb_seq_divider;
   import seq_divider_pkg::*;

   localparam int N = 32;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t fsm_state;

   seq_divider_if #(.N(N)) bus ();

   seq_divider #(.NUMBER_OF_BITS(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic sgn);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.is_signed = sgn;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   // Counts negedges after the accepting edge until done; 0 means it never came.
   task automatic wait_done(input int inject_at, output int lat, output logic busy1);
      lat   = 0;
      busy1 = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 1) busy1 = bus.busy;
         if (c == inject_at) begin
            bus.start    = 1'b1;
            bus.dividend = 9;
            bus.divisor  = 3;
         end
         if (c == inject_at + 1) bus.start = 1'b0;
         if (bus.done) begin
            lat = c;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic run(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic sgn, input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                      input logic exp_z, input int exp_lat, input int inject_at);
      int   lat;
      logic busy1;
      launch(a, b, sgn);
      wait_done(inject_at, lat, busy1);
      check({tag, "_latency"}, N'(lat), N'(exp_lat));
      check({tag, "_busy"}, {31'd0, busy1}, {31'd0, exp_lat > 1});
      check({tag, "_quotient"}, bus.quotient, exp_q);
      check({tag, "_remainder"}, bus.remainder, exp_r);
      check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_z});
      repeat (3) @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_held_q"}, bus.quotient, exp_q);
      check({tag, "_held_r"}, bus.remainder, exp_r);
      check({tag, "_idle"}, N'(fsm_state), N'(IDLE));
   endtask

   initial begin
      int seen;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;

      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_quotient", bus.quotient, 32'd0);
      check("rst_remainder", bus.remainder, 32'd0);
      check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      check("rst_state", N'(fsm_state), N'(IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      run("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 0);
      run("divzero", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1, 0);
      run("restart_ignored", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 33, 10);
      run("max_by_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0);
      run("small_by_big", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33, 0);
      run("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 33, 0);
      run("msb_by_3", 32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA, 32'd2, 1'b0, 33, 0);

      // Abort a running division with reset partway through.
      launch(32'd1000, 32'd3, 1'b0);
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_quotient", bus.quotient, 32'd0);
      check("abort_remainder", bus.remainder, 32'd0);
      check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
      check("abort_state", N'(fsm_state), N'(IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      check("abort_no_done", N'(seen), 32'd0);
      run("after_reset_17_4", 32'd17, 32'd4, 1'b0, 32'd4, 32'd1, 1'b0, 33, 0);

`ifdef SIGNED_DIV_EN
      run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0);
      run("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
      run("s_divzero", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1, 0);
      run("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 0);
`else
      run("ignore_signed", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_BITS, default 32, giving the operand width N (N >= 2).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 is_signed  input  1  selects signed (1) or unsigned (0) operation; used only with SIGNED_DIV_EN.
REQ-006 dividend  input  N  numerator, captured on the accepted start.
REQ-007 divisor  input  N  denominator, captured on the accepted start.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse when quotient/remainder become valid.
REQ-010 quotient  output  N  registered result, held until the next accepted start.
REQ-011 remainder  output  N  registered result, held until the next accepted start.
REQ-012 div_by_zero  output  1  registered flag, high with done when divisor was 0; held with results.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 IDLE -> BUSY on start=1 with divisor!=0; IDLE -> DONE on start=1 with divisor=0; otherwise stay in IDLE.
REQ-015 On an accepted start, operands SHALL be captured, the partial remainder cleared, and the step counter loaded with N.
REQ-016 In BUSY, each cycle SHALL shift {partial remainder, dividend} left by one, trial-subtract the divisor, keep the difference and set quotient bit 1 if non-negative, else restore and set quotient bit 0 (restoring division, one bit per cycle).
REQ-017 BUSY -> DONE after exactly N iterations; DONE -> IDLE unconditionally after one cycle.
REQ-018 Latency: start accepted at edge k, busy high for cycles k+1..k+N, done high only in cycle k+N+1; results valid from that cycle on.
REQ-019 Divide-by-zero: done at cycle k+1, quotient all ones, remainder = dividend, div_by_zero=1.
REQ-020 start while busy or in DONE SHALL be ignored, with no effect on the running operation or operands.
REQ-021 quotient, remainder and div_by_zero SHALL change only in the cycle done asserts, or on reset.
REQ-022 Widths: partial remainder and trial difference SHALL be N+1 bits so the borrow is the sign bit; no result is truncated.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-024 Reset during BUSY SHALL abort the division; no done pulse SHALL follow; the next start after release SHALL behave as from power-up.

Configuration
REQ-025 Macro SIGNED_DIV_EN: when defined, is_signed=1 SHALL convert operands to magnitudes before iteration and fix up signs in DONE: quotient negative iff operand signs differ, remainder takes the dividend's sign.
REQ-026 With SIGNED_DIV_EN, overflow (dividend = most-negative, divisor = -1) SHALL yield quotient = dividend, remainder = 0, same latency N+1; signed divide-by-zero SHALL yield quotient all ones, remainder = dividend.
REQ-027 Without SIGNED_DIV_EN, the is_signed port SHALL remain present but be ignored; all division is unsigned.

Structure
REQ-028 FSM state encoding (IDLE/BUSY/DONE) and the default width constant SHALL live in the shared processor package.
REQ-029 The trial subtraction SHALL be one combinational sub-module, subtractor_nbits (N+1 bits, a - b with borrow out), instantiated once.

Verification
REQ-030 Unsigned 100 / 7, N=32: done exactly 33 cycles after start; quotient=14, remainder=2, div_by_zero=0.
REQ-031 Divisor 0, dividend 0x0000_1234: done 1 cycle after start; quotient=0xFFFF_FFFF, remainder=0x0000_1234, div_by_zero=1.
REQ-032 Start 50/5, then start 9/3 at cycle 10: second start ignored; quotient=10, remainder=0; results held until next start.
REQ-033 rst_n low at cycle 15 of a division: all outputs 0 immediately, no done; a fresh 17/4 then gives 4 r 1 with full latency.
REQ-034 With SIGNED_DIV_EN, is_signed=1: -7 / 2 -> quotient=-3, remainder=-1; 0x8000_0000 / -1 -> quotient=0x8000_0000, remainder=0.
REQ-035 Without SIGNED_DIV_EN, is_signed=1, 0xFFFF_FFF9 / 2 -> quotient=0x7FFF_FFFC, remainder=1.
